multiplexer_8_1: RTL and testbench
==================================

MULTIPLEXER_8_1 -- requirements
Module: multiplexer_8_1

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 1, data bits per lane.
REQ-002 The block SHALL use one clock and a synchronous, active-high reset, with the ports below.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 in_valid  input  8  per-lane request; bit i set = lane i offers data.
REQ-006 in_data  input  8*WIDTH  lane i data on bits [i*WIDTH +: WIDTH].
REQ-007 in_ready  output  8  one-hot or zero grant; lane i transfers when in_valid[i] & in_ready[i].
REQ-008 out  output  WIDTH  registered selected data.
REQ-009 sel  output  3  registered index of the lane that supplied out; drives sel of a downstream 1-to-8 demultiplexer.
REQ-010 out_valid  output  1  out/sel hold a word not yet taken.
REQ-011 out_ready  input  1  consumer accepts out/sel this cycle when out_valid=1.

Function
REQ-012 Output stage SHALL have two states: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-013 load = ~out_valid | out_ready; load is evaluated combinationally each cycle.
REQ-014 Round-robin pointer ptr (3 bits) SHALL hold the index of the last granted lane.
REQ-015 When load=1 and in_valid!=0, the winner g SHALL be the first lane with in_valid set, scanning (ptr+1), (ptr+2), ... mod 8.
REQ-016 in_ready SHALL be 8'b0 except bit g; it is set only when load=1 and in_valid!=0.
REQ-017 in_ready SHALL be combinational from in_valid, out_valid, out_ready and ptr; it SHALL never depend on in_data.
REQ-018 On a grant, the next edge SHALL set out <= lane g data, sel <= g, out_valid <= 1 and ptr <= g.
REQ-019 When load=1 and in_valid=0, the next edge SHALL set out_valid <= 0; out, sel and ptr hold.
REQ-020 When load=0 (FULL with out_ready=0), out, sel, out_valid and ptr SHALL hold; in_ready=0.
REQ-021 Latency: a word granted in cycle N SHALL appear on out/sel with out_valid=1 in cycle N+1.
REQ-022 Simultaneous take and grant (FULL, out_ready=1, in_valid!=0) SHALL replace the word with no bubble; sustained throughput is 1 word/cycle.
REQ-023 ptr wrap-around: after grant to lane 7, lane 0 SHALL have highest priority.
REQ-024 A single persistently valid lane SHALL be granted on every load cycle, not starved by its own priority.
REQ-025 With all 8 lanes valid continuously and out_ready=1, grants SHALL rotate 0,1,...,7,0 with no repeats in 8 cycles.
REQ-026 Dropping in_valid[i] without a grant SHALL be legal and SHALL leave no state change.

Reset
REQ-027 While reset=1 at a clock edge: out_valid<=0, out<=0, sel<=0, ptr<=7; reset overrides any concurrent grant or take.
REQ-028 During reset cycles in_ready SHALL be 0; the first grant after deassertion SHALL favour lane 0.
REQ-029 Reset asserted while FULL SHALL discard the held word; no transfer is reported to the consumer.

Verification
REQ-030 Reset then in_valid=8'hFF, out_ready=1 for 9 cycles -> in_ready = 01,02,04,...,80,01; sel = 0..7,0 one cycle later.
REQ-031 in_valid=8'h24, out_ready=1, ptr=7 -> grant lane 2, then lane 5, then lane 2; lanes 0,1,3,4,6,7 never ready.
REQ-032 Load lane 3 data 1 (WIDTH=1), out_ready=0 for 4 cycles -> out=1, sel=3, out_valid=1 stable, in_ready=0 throughout; out_ready=1 -> taken and next lane granted the same cycle.
REQ-033 in_valid=0 with out_valid=1 and out_ready=1 -> out_valid=0 next cycle; sel and out unchanged.
REQ-034 Grant issued to lane 6 and reset asserted the same cycle -> out_valid=0, sel=0, ptr=7 afterwards; next grant with in_valid=8'h41 goes to lane 0.
REQ-035 Random in_valid/out_ready/in_data, output fed into a 1-to-8 demultiplexer with matching sel -> every transferred word emerges on its source lane index in order; no loss or duplication.

Source files
------------

// File: rtl/multiplexer_8_1.sv
// multiplexer_8_1: 8-lane round-robin arbiter feeding a one-word registered output stage.
// Latency: a lane granted in cycle N is presented on out/sel with out_valid=1 in cycle N+1.
// Backpressure: lanes are granted only while the stage is empty or being taken; 1 word/cycle when out_ready stays high.
//
// Ports:
//   clk, reset           rising-edge clock; synchronous active-high reset
//   in_valid, in_ready   per-lane handshake; in_ready is one-hot or zero
//   in_data              lane i data on bits [i*WIDTH +: WIDTH]
//   out, sel, out_valid  registered word, index of its source lane, word-present flag
//   out_ready            consumer accepts out/sel this cycle when out_valid=1
module multiplexer_8_1 #(
  parameter int WIDTH = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         in_valid,
  input  logic [8*WIDTH-1:0] in_data,
  output logic [7:0]         in_ready,
  output logic [WIDTH-1:0]   out,
  output logic [2:0]         sel,
  output logic               out_valid,
  input  logic               out_ready
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [2:0]       sel_q, sel_d;
  logic [2:0]       ptr_q, ptr_d;

  logic             load;
  logic             any_vld;
  logic             grant_vld;
  logic [2:0]       grant_idx;
  logic [2:0]       scan_idx;
  logic [WIDTH-1:0] grant_dat;

  // Round-robin scan starting just after the last granted lane. The final
  // step (k=8) wraps back onto ptr itself, so a lone persistent requester
  // is still granted every load cycle.
  always_comb begin
    any_vld   = |in_valid;
    grant_vld = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    for (int k = 1; k <= 8; k++) begin
      scan_idx = ptr_q + 3'(k);
      if (!grant_vld && in_valid[scan_idx]) begin
        grant_vld = 1'b1;
        grant_idx = scan_idx;
      end
    end
  end

  // Winning lane's data; the data path never feeds back into the grant.
  always_comb begin
    grant_dat = '0;
    for (int i = 0; i < 8; i++) begin
      if (grant_idx == 3'(i)) begin
        grant_dat = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Stage can accept a new word when empty or when its word leaves this cycle.
  always_comb begin
    load     = (state_q == EMPTY) || out_ready;
    in_ready = 8'b0;
    // Held at zero during reset so no lane believes it transferred a word
    // that the reset is about to drop.
    if (load && any_vld && !reset) begin
      in_ready = 8'b1 << grant_idx;
    end
  end

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    if (load) begin
      if (grant_vld) begin
        state_d = FULL;
        out_d   = grant_dat;
        sel_d   = grant_idx;
        ptr_d   = grant_idx;
      end else begin
        state_d = EMPTY;
      end
    end
  end

  // ptr resets to 7 so lane 0 wins the first arbitration after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      out_q   <= '0;
      sel_q   <= '0;
      ptr_q   <= 3'd7;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out       = out_q;
  assign sel       = sel_q;
  assign out_valid = (state_q == FULL);

endmodule

// File: tb/tb_multiplexer_8_1.sv
// tb_multiplexer_8_1: directed vectors plus a short random phase for multiplexer_8_1.
// Latency: expected words are queued at grant time and popped when the output is taken.
// Backpressure: out_ready is driven per vector / randomly to exercise stalls.
module tb_multiplexer_8_1;

  localparam int W  = 4;
  localparam int NV = 39;
  localparam int NR = 300;

  logic           clk = 1'b0;
  logic           reset;
  logic [7:0]     in_valid;
  logic [8*W-1:0] in_data;
  logic [7:0]     in_ready;
  logic [W-1:0]   out;
  logic [2:0]     sel;
  logic           out_valid;
  logic           out_ready;

  always #5 clk = ~clk;

  multiplexer_8_1 #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out       (out),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // One directed cycle: inputs, then the hand-computed in_ready for this
  // cycle and the out_valid/sel values the registers hold during it.
  typedef struct packed {
    logic       rst;
    logic [7:0] iv;
    logic       ordy;
    logic [7:0] rdy;
    logic       ov;
    logic [2:0] sel;
  } vec_t;

  typedef struct packed {
    logic [2:0]   lane;
    logic [W-1:0] dat;
  } word_t;

  vec_t  vecs [NV];
  word_t exp_q [$];
  word_t mon_w;
  int    errors = 0;
  int    checks = 0;
  logic  done   = 1'b0;

  // Distinct per-lane, per-row data so lane mixups and stale holds show up.
  function automatic logic [8*W-1:0] pattern(input int r);
    logic [8*W-1:0] v;
    for (int i = 0; i < 8; i++) v[i*W +: W] = W'(i * 5 + r * 3 + 1);
    return v;
  endfunction

  function automatic logic [2:0] onehot_idx(input logic [7:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) if (oh[i]) idx = 3'(i);
    return idx;
  endfunction

  initial begin
    //            rst   iv     ordy  rdy    ov    sel
    vecs[0]  = '{1'b1, 8'hFF, 1'b1, 8'h00, 1'b0, 3'd0};
    // all lanes valid: rotate 0..7 then wrap to 0
    vecs[1]  = '{1'b0, 8'hFF, 1'b1, 8'h01, 1'b0, 3'd0};
    vecs[2]  = '{1'b0, 8'hFF, 1'b1, 8'h02, 1'b1, 3'd0};
    vecs[3]  = '{1'b0, 8'hFF, 1'b1, 8'h04, 1'b1, 3'd1};
    vecs[4]  = '{1'b0, 8'hFF, 1'b1, 8'h08, 1'b1, 3'd2};
    vecs[5]  = '{1'b0, 8'hFF, 1'b1, 8'h10, 1'b1, 3'd3};
    vecs[6]  = '{1'b0, 8'hFF, 1'b1, 8'h20, 1'b1, 3'd4};
    vecs[7]  = '{1'b0, 8'hFF, 1'b1, 8'h40, 1'b1, 3'd5};
    vecs[8]  = '{1'b0, 8'hFF, 1'b1, 8'h80, 1'b1, 3'd6};
    vecs[9]  = '{1'b0, 8'hFF, 1'b1, 8'h01, 1'b1, 3'd7};
    // drain to empty; sel holds
    vecs[10] = '{1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 3'd0};
    vecs[11] = '{1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 3'd0};
    // reset then lanes 2 and 5 alternate
    vecs[12] = '{1'b1, 8'h24, 1'b1, 8'h00, 1'b0, 3'd0};
    vecs[13] = '{1'b0, 8'h24, 1'b1, 8'h04, 1'b0, 3'd0};
    vecs[14] = '{1'b0, 8'h24, 1'b1, 8'h20, 1'b1, 3'd2};
    vecs[15] = '{1'b0, 8'h24, 1'b1, 8'h04, 1'b1, 3'd5};
    // load lane 3, stall 4 cycles, then take and grant together
    vecs[16] = '{1'b0, 8'h08, 1'b1, 8'h08, 1'b1, 3'd2};
    vecs[17] = '{1'b0, 8'hFF, 1'b0, 8'h00, 1'b1, 3'd3};
    vecs[18] = '{1'b0, 8'hFF, 1'b0, 8'h00, 1'b1, 3'd3};
    vecs[19] = '{1'b0, 8'hFF, 1'b0, 8'h00, 1'b1, 3'd3};
    vecs[20] = '{1'b0, 8'hFF, 1'b0, 8'h00, 1'b1, 3'd3};
    vecs[21] = '{1'b0, 8'hFF, 1'b1, 8'h10, 1'b1, 3'd3};
    // single persistent lane keeps winning
    vecs[22] = '{1'b0, 8'h10, 1'b1, 8'h10, 1'b1, 3'd4};
    vecs[23] = '{1'b0, 8'h10, 1'b1, 8'h10, 1'b1, 3'd4};
    vecs[24] = '{1'b0, 8'h10, 1'b1, 8'h10, 1'b1, 3'd4};
    // requests dropped while stalled leave nothing behind
    vecs[25] = '{1'b0, 8'h02, 1'b0, 8'h00, 1'b1, 3'd4};
    vecs[26] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 3'd4};
    vecs[27] = '{1'b0, 8'h80, 1'b1, 8'h80, 1'b1, 3'd4};
    // take with nothing pending: empty next cycle, sel held
    vecs[28] = '{1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 3'd7};
    // grant lane 6, then reset while full discards it
    vecs[29] = '{1'b0, 8'h40, 1'b1, 8'h40, 1'b0, 3'd7};
    vecs[30] = '{1'b1, 8'h40, 1'b1, 8'h00, 1'b1, 3'd6};
    vecs[31] = '{1'b0, 8'h41, 1'b1, 8'h01, 1'b0, 3'd0};
    vecs[32] = '{1'b0, 8'h41, 1'b1, 8'h40, 1'b1, 3'd0};
    vecs[33] = '{1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 3'd6};
    // empty stage loads even with out_ready low, wrapping 7 -> 0
    vecs[34] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 3'd6};
    vecs[35] = '{1'b0, 8'h01, 1'b0, 8'h01, 1'b0, 3'd6};
    vecs[36] = '{1'b0, 8'h01, 1'b0, 8'h00, 1'b1, 3'd0};
    vecs[37] = '{1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 3'd0};
    vecs[38] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0};
  end

  // Driver: inputs change 1 time unit after the edge, checks 1 unit later.
  initial begin
    logic [2:0]     lane;
    logic [8*W-1:0] pat;
    logic           legal;
    reset     = 1'b1;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);

    for (int r = 0; r < NV; r++) begin
      #1;
      reset     = vecs[r].rst;
      in_valid  = vecs[r].iv;
      out_ready = vecs[r].ordy;
      pat       = pattern(r);
      in_data   = pat;
      if (vecs[r].rst) exp_q.delete();
      #1;
      checks++;
      if (in_ready !== vecs[r].rdy) begin
        errors++;
        $display("FAIL in_ready row %0d: got %h expected %h", r, in_ready, vecs[r].rdy);
      end
      checks++;
      if (out_valid !== vecs[r].ov) begin
        errors++;
        $display("FAIL out_valid row %0d: got %b expected %b", r, out_valid, vecs[r].ov);
      end
      checks++;
      if (sel !== vecs[r].sel) begin
        errors++;
        $display("FAIL sel row %0d: got %0d expected %0d", r, sel, vecs[r].sel);
      end
      if (vecs[r].rdy != 8'h00) begin
        lane = onehot_idx(vecs[r].rdy);
        exp_q.push_back('{lane: lane, dat: pat[lane*W +: W]});
      end
      @(posedge clk);
    end

    // Random traffic: words are queued on every observed handshake and must
    // come out on the same lane index, in order, exactly once.
    for (int r = 0; r < NR; r++) begin
      #1;
      reset     = 1'b0;
      in_valid  = (r % 3 == 0) ? 8'($urandom) : 8'($urandom & $urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      in_data   = 32'($urandom);
      #1;
      legal = ((in_ready & ~in_valid) == 8'h00) && $onehot0(in_ready) &&
              ((in_ready != 8'h00) == ((in_valid != 8'h00) && (!out_valid || out_ready)));
      checks++;
      if (!legal) begin
        errors++;
        $display("FAIL grant_legal rand %0d: in_ready=%h in_valid=%h out_valid=%b out_ready=%b",
                 r, in_ready, in_valid, out_valid, out_ready);
      end
      if (in_ready != 8'h00) begin
        lane = onehot_idx(in_ready);
        exp_q.push_back('{lane: lane, dat: in_data[lane*W +: W]});
      end
      @(posedge clk);
    end

    #1;
    in_valid  = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    done = 1'b1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d words never emerged, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Monitor: models the downstream 1-to-8 demux; every taken word must match
  // the oldest outstanding grant in both lane index and data.
  always @(negedge clk) begin
    if (!done && reset === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_word: got lane %0d data %h, expected no word", sel, out);
      end else begin
        mon_w = exp_q.pop_front();
        if (sel !== mon_w.lane || out !== mon_w.dat) begin
          errors++;
          $display("FAIL word: got lane %0d data %h, expected lane %0d data %h",
                   sel, out, mon_w.lane, mon_w.dat);
        end
      end
    end
  end

endmodule
